// File: rtl/hazard_scoreboard_unit.sv
// ============================================================================
// Module  : hazard_scoreboard_unit
// Brief   : ID-stage hazard scoreboard with countdown counters, mul/div
//           occupancy tracking and a saturating stall-cycle counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_scoreboard_unit #(
    parameter int REG_AW       = 5,
    parameter int ALU_LAT      = 0,
    parameter int LOAD_LAT     = 1,
    parameter int MULDIV_LAT   = 4,
    parameter int BRANCH_EXTRA = 1,
    parameter int CNT_W        = 3,
    parameter int PERF_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              id_kill,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_rt_late,
    input  logic              id_is_branch,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_wr_reg,
    input  logic [1:0]        id_class,
    output logic              pcHold,
    output logic              ifidHold,
    output logic              idexBubble,
    output logic [1:0]        stall_cause,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam int NREG = 2**REG_AW;

    localparam logic [CNT_W-1:0] LD_ALU    = CNT_W'(ALU_LAT + BRANCH_EXTRA);
    localparam logic [CNT_W-1:0] LD_LOAD   = CNT_W'(LOAD_LAT + BRANCH_EXTRA);
    localparam logic [CNT_W-1:0] LD_MULDIV = CNT_W'(MULDIV_LAT + BRANCH_EXTRA);
    localparam logic [CNT_W-1:0] BUSY_LD   = CNT_W'(MULDIV_LAT);
    localparam logic [CNT_W-1:0] TH_NORM   = CNT_W'(BRANCH_EXTRA);
    localparam logic [CNT_W-1:0] TH_LATE   = CNT_W'(BRANCH_EXTRA + 1);

    localparam logic [1:0] CLS_LOAD   = 2'd1;
    localparam logic [1:0] CLS_MULDIV = 2'd2;

    logic [CNT_W-1:0] cnt [NREG];
    logic [CNT_W-1:0] busy;

    logic             active;
    logic [CNT_W-1:0] th_rs;
    logic [CNT_W-1:0] th_rt;
    logic             haz_rs;
    logic             haz_rt;
    logic             data_stall;
    logic             struct_stall;
    logic             stall;
    logic             issue;
    logic [CNT_W-1:0] ld_val;

    always_comb begin
        active       = id_valid & ~id_kill;
        // Branches resolve in ID and need the value one stage earlier than EX.
        th_rs        = id_is_branch ? '0 : TH_NORM;
        th_rt        = id_is_branch ? '0 : (id_rt_late ? TH_LATE : TH_NORM);
        haz_rs       = id_use_rs && (id_rs != '0) && (cnt[id_rs] > th_rs);
        haz_rt       = id_use_rt && (id_rt != '0) && (cnt[id_rt] > th_rt);
        data_stall   = active & (haz_rs | haz_rt);
        struct_stall = active & (id_class == CLS_MULDIV) & (busy != '0);
        stall        = data_stall | struct_stall;
        issue        = active & ~stall;

        stall_cause = 2'd0;
        if (data_stall) begin
            stall_cause = 2'd1;
        end else if (struct_stall) begin
            stall_cause = 2'd2;
        end

        case (id_class)
            CLS_LOAD:   ld_val = LD_LOAD;
            CLS_MULDIV: ld_val = LD_MULDIV;
            default:    ld_val = LD_ALU;
        endcase
    end

    assign pcHold     = stall;
    assign ifidHold   = stall;
    assign idexBubble = stall;

    // Register 0 is never loaded, so its counter stays at zero from reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (issue && id_wr_en && (id_wr_reg != '0) &&
                    (id_wr_reg == REG_AW'(r))) begin
                    cnt[r] <= ld_val;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else if (issue && (id_class == CLS_MULDIV)) begin
            busy <= BUSY_LD;
        end else if (busy != '0) begin
            busy <= busy - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard_unit.sv
// ============================================================================
// Module  : tb_hazard_scoreboard_unit
// Brief   : Randomised and directed bench with a cycle-time reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard_unit;

    localparam int BE      = 1;
    localparam int LAT_ALU = 0;
    localparam int LAT_LD  = 1;
    localparam int LAT_MD  = 4;
    localparam int PMAX    = 65535;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic        id_kill = 1'b0;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic        id_use_rs = 1'b0;
    logic        id_use_rt = 1'b0;
    logic        id_rt_late = 1'b0;
    logic        id_is_branch = 1'b0;
    logic        id_wr_en = 1'b0;
    logic [4:0]  id_wr_reg = '0;
    logic [1:0]  id_class = '0;
    logic        pcHold;
    logic        ifidHold;
    logic        idexBubble;
    logic [1:0]  stall_cause;
    logic [15:0] stall_cycles;

    hazard_scoreboard_unit dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_kill(id_kill),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_rt_late(id_rt_late), .id_is_branch(id_is_branch), .id_wr_en(id_wr_en),
        .id_wr_reg(id_wr_reg), .id_class(id_class), .pcHold(pcHold),
        .ifidHold(ifidHold), .idexBubble(idexBubble), .stall_cause(stall_cause),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit stall;
        int cause;
        int perf;
    } exp_t;

    exp_t   exp_q[$];
    int     n_checks = 0;
    int     n_errors = 0;

    // Model: absolute cycle at which each register / the mul/div unit is free.
    longint ready_at [32];
    longint busy_until = 0;
    longint now = 0;
    int     perf = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, req, now);
        end
    endtask

    function automatic longint rem(input int r);
        return (r == 0 || ready_at[r] <= now) ? 0 : ready_at[r] - now;
    endfunction

    function automatic int lat_of(input int cls);
        return (cls == 1) ? LAT_LD : (cls == 2) ? LAT_MD : LAT_ALU;
    endfunction

    task automatic model_reset();
        foreach (ready_at[i]) ready_at[i] = 0;
        busy_until = 0;
        perf = 0;
    endtask

    task automatic set_in(input bit v, k, input int rs, rt, input bit urs, urt, late, br,
                          wen, input int wr, cls);
        id_valid = v; id_kill = k; id_rs = 5'(rs); id_rt = 5'(rt);
        id_use_rs = urs; id_use_rt = urt; id_rt_late = late; id_is_branch = br;
        id_wr_en = wen; id_wr_reg = 5'(wr); id_class = 2'(cls);
    endtask

    // One pipeline cycle: apply inputs, predict, advance model across the edge.
    task automatic drive(input bit v, k, input int rs, rt, input bit urs, urt, late, br,
                         wen, input int wr, cls, output bit st);
        exp_t e;
        bit   act, dstall, sstall;
        int   th_rs, th_rt;
        set_in(v, k, rs, rt, urs, urt, late, br, wen, wr, cls);
        act    = v && !k;
        th_rs  = br ? 0 : BE;
        th_rt  = br ? 0 : (late ? BE + 1 : BE);
        dstall = act && ((urs && rem(rs) > th_rs) || (urt && rem(rt) > th_rt));
        sstall = act && (cls == 2) && (busy_until > now);
        e.stall = dstall || sstall;
        e.cause = dstall ? 1 : (sstall ? 2 : 0);
        e.perf  = perf;
        exp_q.push_back(e);
        #1;
        st = pcHold;
        @(posedge clk);
        if (act && !e.stall) begin
            if (wen && wr != 0) ready_at[wr] = now + 1 + lat_of(cls) + BE;
            if (cls == 2) busy_until = now + 1 + LAT_MD;
        end
        if (e.stall && perf < PMAX) perf++;
        now++;
        #1;
    endtask

    task automatic idle(input int n);
        bit st;
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st);
    endtask

    // Present one instruction until it issues; count cycles the DUT held it.
    task automatic instr(input string nm, input int exp_st, input int rs, rt,
                         input bit urs, urt, late, br, wen, input int wr, cls);
        int n = 0;
        bit st;
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, rs, rt, urs, urt, late, br, wen, wr, cls, st);
            if (!st) break;
            n++;
        end
        chk(nm, n, exp_st);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (rst_n) begin
                chk("pcHold", int'(pcHold), int'(e.stall));
                chk("ifidHold", int'(ifidHold), int'(e.stall));
                chk("idexBubble", int'(idexBubble), int'(e.stall));
                chk("stall_cause", int'(stall_cause), e.cause);
                chk("stall_cycles", int'(stall_cycles), e.perf);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        bit st;
        int rs, rt, wr, cls;
        bit v, k, urs, urt, late, br, wen;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pcHold", int'(pcHold), 0);
        chk("reset_cause", int'(stall_cause), 0);
        chk("reset_perf", int'(stall_cycles), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU producer followed by branch / normal consumer.
        instr("add3", 0, 1, 2, 1, 1, 0, 0, 1, 3, 0);
        instr("beq_after_add", 1, 3, 4, 1, 1, 0, 1, 0, 0, 0);
        idle(8);
        instr("add3b", 0, 1, 2, 1, 1, 0, 0, 1, 3, 0);
        instr("add_after_add", 0, 3, 0, 1, 0, 0, 0, 1, 5, 0);
        idle(8);
        // Load-use cases.
        instr("lw7", 0, 1, 0, 1, 0, 0, 0, 1, 7, 1);
        instr("add_after_lw", 1, 7, 1, 1, 1, 0, 0, 1, 8, 0);
        idle(8);
        instr("lw7b", 0, 1, 0, 1, 0, 0, 0, 1, 7, 1);
        instr("beq_after_lw", 2, 7, 2, 1, 1, 0, 1, 0, 0, 0);
        idle(8);
        instr("lw7c", 0, 1, 0, 1, 0, 0, 0, 1, 7, 1);
        instr("sw_late_data", 0, 9, 7, 1, 1, 1, 0, 0, 0, 0);
        idle(8);
        instr("lw9", 0, 1, 0, 1, 0, 0, 0, 1, 9, 1);
        instr("sw_base_dep", 1, 9, 7, 1, 1, 1, 0, 0, 0, 0);
        idle(8);
        // Mul/div structural and data hazards.
        instr("mult1", 0, 1, 2, 1, 1, 0, 0, 1, 10, 2);
        instr("mult2_busy", 4, 4, 5, 1, 1, 0, 0, 1, 11, 2);
        idle(8);
        instr("mult3", 0, 1, 2, 1, 1, 0, 0, 1, 10, 2);
        instr("add_after_mult", 4, 10, 0, 1, 0, 0, 0, 1, 12, 0);
        idle(8);
        // Register 0 and self-dependence.
        instr("lw0", 0, 1, 0, 1, 0, 0, 0, 1, 0, 1);
        instr("use_r0", 0, 0, 0, 1, 1, 0, 1, 1, 13, 0);
        instr("lw14", 0, 1, 0, 1, 0, 0, 0, 1, 14, 1);
        instr("self_dep", 0, 14, 0, 0, 0, 0, 0, 1, 14, 0);
        idle(8);
        // Kill drops a pending stall in the same cycle and writes nothing.
        instr("lw7d", 0, 1, 0, 1, 0, 0, 0, 1, 7, 1);
        set_in(1, 0, 7, 1, 1, 1, 0, 0, 1, 8, 0);
        #1;
        chk("stall_before_kill", int'(pcHold), 1);
        drive(1, 1, 7, 1, 1, 1, 0, 0, 1, 8, 0, st);
        chk("kill_drop", int'(st), 0);
        instr("after_kill", 0, 8, 0, 1, 0, 0, 0, 1, 9, 0);
        idle(8);
        // Asynchronous reset while a mul/div stall is showing.
        instr("mult4", 0, 1, 2, 1, 1, 0, 0, 1, 10, 2);
        set_in(1, 0, 4, 5, 1, 1, 0, 0, 1, 11, 2);
        #1;
        chk("md_stall_pre_rst", int'(pcHold), 1);
        chk("md_cause_pre_rst", int'(stall_cause), 2);
        rst_n = 1'b0;
        #1;
        chk("rst_pcHold", int'(pcHold), 0);
        chk("rst_ifidHold", int'(ifidHold), 0);
        chk("rst_idexBubble", int'(idexBubble), 0);
        chk("rst_cause", int'(stall_cause), 0);
        chk("rst_perf", int'(stall_cycles), 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomised traffic; a stalled instruction is usually held in ID.
        v = 0; k = 0; rs = 0; rt = 0; urs = 0; urt = 0; late = 0; br = 0; wen = 0;
        wr = 0; cls = 0; st = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!st || $urandom_range(3) == 0) begin
                v    = $urandom_range(99) < 85;
                rs   = $urandom_range(7);
                rt   = $urandom_range(7);
                urs  = $urandom_range(1);
                urt  = $urandom_range(1);
                br   = $urandom_range(4) == 0;
                late = !br && $urandom_range(3) == 0;
                wen  = $urandom_range(3) != 0;
                wr   = $urandom_range(7);
                cls  = $urandom_range(3);
            end
            k = $urandom_range(9) == 0;
            drive(v, k, rs, rt, urs, urt, late, br, wen, wr, cls, st);
        end
        idle(8);

        // Back-to-back mul/div drives the stall counter into saturation.
        for (int i = 0; i < 82000; i++)
            drive(1, 0, 1, 2, 1, 1, 0, 0, 1, 10, 2, st);
        chk("perf_saturated", int'(stall_cycles), 16'hFFFF);
        idle(8);
        chk("perf_holds", int'(stall_cycles), 16'hFFFF);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Parametrised, stateful successor to the combinational stall logic of the 5-stage MIPS pipeline.
- Sits beside the ID stage. Holds a per-register countdown scoreboard of in-flight results, a busy counter for the non-pipelined mul/div unit, and a stall-cycle performance counter.
- Drives PC hold, IF/ID hold and an ID/EX bubble. Covers ALU, load, mul/div, branch-in-ID and store-data-late cases with configurable latencies.

Parameters:
- REG_AW, 5, register address width; 2**REG_AW registers are tracked, register 0 never.
- ALU_LAT, 0, extra cycles before an ALU result can be forwarded to the EX of a dependent instruction.
- LOAD_LAT, 1, the same for loads.
- MULDIV_LAT, 4, the same for mul/div; this is also the mul/div unit occupancy in cycles.
- BRANCH_EXTRA, 1, extra cycles a branch needs because it compares its operands in ID.
- CNT_W, 3, scoreboard counter width; must satisfy MULDIV_LAT+BRANCH_EXTRA <= 2**CNT_W-1.
- PERF_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_kill  in  1  the ID instruction is being flushed (taken branch or jump); it must not issue.
- id_rs  in  REG_AW  source register rs.
- id_rt  in  REG_AW  source register rt.
- id_use_rs  in  1  the instruction reads rs.
- id_use_rt  in  1  the instruction reads rt.
- id_rt_late  in  1  rt is needed only in MEM (store data).
- id_is_branch  in  1  the instruction compares its operands in ID.
- id_wr_en  in  1  the instruction writes a register.
- id_wr_reg  in  REG_AW  destination register.
- id_class  in  2  0=ALU, 1=load, 2=mul/div, 3=reserved (treated as ALU).
- pcHold  out  1  freeze the PC.
- ifidHold  out  1  freeze IF/ID.
- idexBubble  out  1  load a NOP into ID/EX.
- stall_cause  out  2  0=none, 1=data, 2=mul/div busy.
- stall_cycles  out  PERF_W  saturating count of stalled cycles.

Behaviour:
- Reset (async, rst_n=0): all scoreboard counters 0, muldiv busy counter 0, stall_cycles 0. All stall outputs read 0 whenever the counters are 0.
- Scoreboard cnt[r] semantics: cnt[r] is the number of cycles until register r is forwardable to the consumer's required stage. Each edge, every nonzero cnt decrements by 1.
- Operand thresholds. Let TH be the threshold for an operand; a data stall is raised when the operand is used, its register is nonzero, and cnt > TH.
  - Branch operands: TH = 0.
  - Normal operands: TH = BRANCH_EXTRA.
  - rt with id_rt_late=1: TH = BRANCH_EXTRA+1.
- Structural stall: raised when id_class=2 and the busy counter is nonzero.
- Stall conditions are evaluated only when id_valid=1 and id_kill=0.
- stall = data stall OR structural stall; this path is combinational. pcHold = ifidHold = idexBubble = stall.
- stall_cause: 1 has priority over 2.
- Issue: issue = id_valid & ~id_kill & ~stall. On issue with id_wr_en=1 and id_wr_reg != 0, cnt[id_wr_reg] loads class LAT + BRANCH_EXTRA at the edge.
  - The load wins over the decrement for the same register.
  - A new writer of a register overwrites any older pending count.
- On issue with id_class=2, the busy counter loads MULDIV_LAT. Otherwise it decrements to 0.
- Killed or stalled instructions never modify the scoreboard.
- stall_cycles increments on each edge where stall=1 and saturates at all-ones.
- A source equal to id_wr_reg of the same instruction uses the old cnt; self-dependence is not a hazard.
- Reset mid-stall clears all state immediately; the outputs drop asynchronously.

Test Plan:
- Defaults. add $3 issues, then beq $3,$4 → 1 stall cycle (stall_cause=1), then issues. The same pair with add $5,$3 instead of beq → 0 stalls.
- lw $7 issues, then add $8,$7,$1 → exactly 1 cycle with pcHold=ifidHold=idexBubble=1. lw $7 then beq $7,$2 → exactly 2 stall cycles.
- lw $7, then sw $7,0($9) with id_rt_late=1 → no stall. lw $9, then sw $7,0($9) → 1 stall.
- mult issues, then a second mult → 4 stall cycles with stall_cause=2. A dependent add on the mult destination → stall_cause=1 for 4 cycles.
- Write to $0 by lw, then a consumer of $0 → no stall. A stalled consumer with id_kill=1 asserted → stall drops the same cycle and the scoreboard is unchanged.
- Assert rst_n=0 during a mul/div stall → outputs 0 with no clock edge, stall_cycles=0. Force 2**16 stall cycles → stall_cycles holds 16'hFFFF.
